// File: rtl/reglk_init_master.sv
// Register-lock table initiator: programs NB_WORDS lock words over a register
// bus, reads them all back and reports done or the first fault with its index.
module reglk_init_master #(
  parameter int unsigned NB_WORDS  = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned IDX_W    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [32*NB_WORDS-1:0]   lock_words_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [1:0]               err_code_o,
  output logic [IDX_W-1:0]         err_idx_o,
  output logic [31:0]              reg_addr,
  output logic                     reg_write,
  output logic [31:0]              reg_wdata,
  output logic [3:0]               reg_wstrb,
  output logic                     reg_valid,
  input  logic [31:0]              reg_rdata,
  input  logic                     reg_ready,
  input  logic                     reg_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DONE, ERROR} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt, err_idx_nxt;
  logic [1:0]            err_code_nxt;
  logic [CNT_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic [32*NB_WORDS-1:0] snap, snap_src;
  logic                  load, accept, stall, on_bus_nxt;
  logic [31:0]           cur_word, wdata_nxt;

  assign accept   = reg_valid && reg_ready;
  assign stall    = reg_valid && !reg_ready;
  assign cur_word = snap[32*idx +: 32];

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    err_code_nxt = err_code_o;
    err_idx_nxt  = err_idx_o;
    tmo_cnt_nxt  = tmo_cnt;
    load         = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          load         = 1'b1;
          state_nxt    = WRITE;
          idx_nxt      = '0;
          err_code_nxt = 2'd0;
          err_idx_nxt  = '0;
          tmo_cnt_nxt  = '0;
        end
      end
      WRITE, READ: begin
        if (accept) begin
          tmo_cnt_nxt = '0;
          if (reg_error) begin
            state_nxt    = ERROR;
            err_code_nxt = 2'd1;
            err_idx_nxt  = idx;
          end else if (state == READ && reg_rdata != cur_word) begin
            state_nxt    = ERROR;
            err_code_nxt = 2'd2;
            err_idx_nxt  = idx;
          end else if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = (state == WRITE) ? READ : DONE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else if (stall) begin
          if (tmo_cnt == TMO_LAST) begin
            state_nxt    = ERROR;
            err_code_nxt = 2'd3;
            err_idx_nxt  = idx;
            tmo_cnt_nxt  = '0;
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      idx        <= '0;
      tmo_cnt    <= '0;
      err_code_o <= 2'd0;
      err_idx_o  <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      err_code_o <= err_code_nxt;
      err_idx_o  <= err_idx_nxt;
    end
  end

  // NOTE: the snapshot is loaded before any use, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (load) snap <= lock_words_i;
  end

  // Bus outputs are registered from next-state values so the request appears
  // the cycle after the decision, with no path from reg_ready to the bus.
  assign snap_src   = load ? lock_words_i : snap;
  assign wdata_nxt  = snap_src[32*idx_nxt +: 32];
  assign on_bus_nxt = (state_nxt == WRITE) || (state_nxt == READ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_valid <= 1'b0;
      reg_write <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= 4'h0;
    end else begin
      reg_valid <= on_bus_nxt;
      reg_write <= (state_nxt == WRITE);
      reg_addr  <= on_bus_nxt ? BASE_ADDR + (32'(idx_nxt) << 2) : 32'h0;
      reg_wdata <= (state_nxt == WRITE) ? wdata_nxt : 32'h0;
      reg_wstrb <= (state_nxt == WRITE) ? 4'hF : 4'h0;
    end
  end

  assign busy_o  = (state == WRITE) || (state == READ);
  assign done_o  = (state == DONE);
  assign error_o = (state == ERROR);

endmodule

// File: tb/tb_reglk_init_master.sv
// Bench for reglk_init_master: a storing responder, a transfer-count model of
// the program/verify sequence, directed scenarios and randomized sequences.
module tb_reglk_init_master;

  localparam int NB  = 6;
  localparam int TMO = 16;
  localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [32*NB-1:0]  lock_words_i = '0;
  logic              busy_o, done_o, error_o;
  logic [1:0]        err_code_o;
  logic [2:0]        err_idx_o;
  logic [31:0]       reg_addr, reg_wdata, reg_rdata;
  logic              reg_write, reg_valid, reg_ready, reg_error;
  logic [3:0]        reg_wstrb;

  // Responder controls
  logic        ready_drv = 1'b1;
  logic        err_en = 1'b0, err_wr = 1'b0, corrupt_en = 1'b0;
  logic [31:0] err_addr = '0, corrupt_addr = '0;
  logic [31:0] resp_mem [8];

  int total = 0;
  int bad = 0;

  reglk_init_master #(.NB_WORDS(NB), .BASE_ADDR(32'h0), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .lock_words_i(lock_words_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_code_o(err_code_o), .err_idx_o(err_idx_o),
    .reg_addr(reg_addr), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_valid(reg_valid),
    .reg_rdata(reg_rdata), .reg_ready(reg_ready), .reg_error(reg_error)
  );

  always #5 clk_i = ~clk_i;

  // Storing responder
  assign reg_ready = ready_drv;
  assign reg_error = err_en && (reg_write == err_wr) && (reg_addr == err_addr);
  assign reg_rdata = (corrupt_en && reg_addr == corrupt_addr) ? BAD_WORD : resp_mem[reg_addr[4:2]];

  always @(posedge clk_i) begin
    if (reg_valid && reg_ready && reg_write) resp_mem[reg_addr[4:2]] <= reg_wdata;
  end

  // Model: the whole run is 2*NB transfers numbered k; the first NB write,
  // the rest read back, transfer k targets word k mod NB.
  logic        m_run = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [1:0]  m_code = '0;
  logic [2:0]  m_idx = '0;
  int          m_k = 0, m_stall = 0;
  logic [31:0] m_snap [NB];
  logic [31:0] m_mem  [NB];

  always @(posedge clk_i or negedge rst_ni) begin : model
    int i;
    bit wr;
    logic [31:0] rd;
    if (!rst_ni) begin
      m_run <= 0; m_done <= 0; m_err <= 0; m_code <= 0; m_idx <= 0; m_k <= 0; m_stall <= 0;
    end else if (!m_run) begin
      if (start_i) begin
        for (int j = 0; j < NB; j++) m_snap[j] <= lock_words_i[32*j +: 32];
        m_run <= 1; m_done <= 0; m_err <= 0; m_code <= 0; m_idx <= 0; m_k <= 0; m_stall <= 0;
      end
    end else begin
      i  = m_k % NB;
      wr = (m_k < NB);
      if (ready_drv) begin
        m_stall <= 0;
        rd = (corrupt_en && 32'(4*i) == corrupt_addr) ? BAD_WORD : m_mem[i];
        if (err_en && wr == err_wr && 32'(4*i) == err_addr) begin
          m_run <= 0; m_err <= 1; m_code <= 2'd1; m_idx <= 3'(i);
        end else if (!wr && rd != m_snap[i]) begin
          m_run <= 0; m_err <= 1; m_code <= 2'd2; m_idx <= 3'(i);
        end else begin
          if (wr) m_mem[i] <= m_snap[i];
          if (m_k == 2*NB-1) begin m_run <= 0; m_done <= 1; end
          m_k <= m_k + 1;
        end
      end else if (m_stall + 1 >= TMO) begin
        m_run <= 0; m_err <= 1; m_code <= 2'd3; m_idx <= 3'(i);
      end else begin
        m_stall <= m_stall + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus a log of accepted transfers
  logic [32:0] log_q [$];
  int busy_cnt = 0;

  always @(negedge clk_i) begin
    check("busy", busy_o, m_run);
    check("done", done_o, m_done);
    check("error", error_o, m_err);
    check("err_code", err_code_o, m_code);
    check("err_idx", err_idx_o, m_idx);
    check("valid", reg_valid, m_run);
    if (m_run) begin
      check("write", reg_write, m_k < NB);
      check("addr", reg_addr, 32'(4*(m_k % NB)));
      check("wdata", reg_wdata, (m_k < NB) ? m_snap[m_k % NB] : 32'h0);
      check("wstrb", reg_wstrb, (m_k < NB) ? 32'hF : 32'h0);
    end
    if (rst_ni && reg_valid && reg_ready) log_q.push_back({reg_write, reg_addr});
    if (busy_o) busy_cnt++;
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic kick();
    log_q.delete();
    busy_cnt = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_end(input int bound, output int n);
    n = 0;
    while (!(done_o || error_o) && n < bound) begin
      step();
      n++;
    end
    if (!(done_o || error_o)) begin
      total++;
      bad++;
      $display("FAIL wait_end: no done or error within %0d cycles", bound);
    end
  endtask

  initial begin
    int n, n2, reads;
    for (int j = 0; j < 8; j++) resp_mem[j] = '0;
    for (int j = 0; j < NB; j++) m_mem[j] = '0;

    // Reset state
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_valid", reg_valid, 0);
    check("rst_code", err_code_o, 0);
    repeat (3) step();
    rst_ni = 1'b1;
    step();

    // Full clean sequence with words 11111111..66666666
    for (int j = 0; j < NB; j++) lock_words_i[32*j +: 32] = {8{4'(j + 1)}};
    kick();
    wait_end(100, n);
    check("t1_cycles", n, 12);
    check("t1_done", done_o, 1);
    check("t1_error", error_o, 0);
    step();
    check("t1_busy_cycles", busy_cnt, 12);
    check("t1_log_len", log_q.size(), 12);
    for (int j = 0; j < log_q.size() && j < 12; j++) begin
      check("t1_log_write", log_q[j][32], (j < NB) ? 1 : 0);
      check("t1_log_addr", log_q[j][31:0], 32'(4*(j % NB)));
    end

    // Corrupted read of word 3
    corrupt_en = 1'b1; corrupt_addr = 32'h0C;
    kick();
    wait_end(100, n);
    check("t2_error", error_o, 1);
    check("t2_code", err_code_o, 2);
    check("t2_idx", err_idx_o, 3);
    check("t2_done", done_o, 0);
    check("t2_log_len", log_q.size(), 10);
    if (log_q.size() > 0) check("t2_last", log_q[log_q.size()-1], {1'b0, 32'h0C});
    corrupt_en = 1'b0;

    // Three stall cycles on the write of word 2
    kick();
    step(); step();
    ready_drv = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("t3_addr", reg_addr, 32'h08);
      check("t3_wdata", reg_wdata, 32'h33333333);
      step();
    end
    check("t3_addr_end", reg_addr, 32'h08);
    ready_drv = 1'b1;
    wait_end(100, n2);
    check("t3_cycles", 5 + n2, 15);
    check("t3_done", done_o, 1);

    // Ready stuck low: timeout after TMO edges
    ready_drv = 1'b0;
    kick();
    wait_end(100, n);
    check("t4_cycles", n, TMO);
    check("t4_code", err_code_o, 3);
    check("t4_idx", err_idx_o, 0);
    step();
    check("t4_valid", reg_valid, 0);
    ready_drv = 1'b1;

    // Bus error on write of word 1
    err_en = 1'b1; err_wr = 1'b1; err_addr = 32'h04;
    kick();
    wait_end(100, n);
    check("t5_cycles", n, 2);
    check("t5_code", err_code_o, 1);
    check("t5_idx", err_idx_o, 1);
    reads = 0;
    foreach (log_q[j]) if (!log_q[j][32]) reads++;
    check("t5_reads", reads, 0);
    err_en = 1'b0;

    // Reset in the middle of the read of word 2, then a fresh full run
    kick();
    repeat (8) step();
    check("t6_valid_pre", reg_valid, 1);
    check("t6_write_pre", reg_write, 0);
    check("t6_addr_pre", reg_addr, 32'h08);
    #1 rst_ni = 1'b0;
    #1;
    check("t6_valid", reg_valid, 0);
    check("t6_write", reg_write, 0);
    check("t6_addr", reg_addr, 0);
    check("t6_wdata", reg_wdata, 0);
    check("t6_wstrb", reg_wstrb, 0);
    check("t6_busy", busy_o, 0);
    check("t6_done", done_o, 0);
    check("t6_error", error_o, 0);
    check("t6_code", err_code_o, 0);
    check("t6_idx", err_idx_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    for (int j = 0; j < NB; j++) lock_words_i[32*j +: 32] = $urandom();
    kick();
    wait_end(100, n);
    check("t6_cycles", n, 12);
    check("t6_done_end", done_o, 1);

    // Randomized sequences: stalls, stray starts, word changes, fault injection
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < NB; j++) lock_words_i[32*j +: 32] = $urandom();
      corrupt_en   = ($urandom_range(0, 3) == 0);
      corrupt_addr = 32'(4 * $urandom_range(0, NB-1));
      err_en       = ($urandom_range(0, 4) == 0);
      err_wr       = 1'($urandom_range(0, 1));
      err_addr     = 32'(4 * $urandom_range(0, NB-1));
      ready_drv    = 1'b1;
      kick();
      n = 0;
      while (!(done_o || error_o) && n < 500) begin
        ready_drv = ($urandom_range(0, 3) != 0);
        start_i   = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 7) == 0)
          lock_words_i[32*$urandom_range(0, NB-1) +: 32] = $urandom();
        step();
        n++;
      end
      start_i = 1'b0;
      ready_drv = 1'b1;
      if (!(done_o || error_o)) begin
        total++;
        bad++;
        $display("FAIL rand_end: iteration %0d did not finish", it);
      end
      step();
    end
    corrupt_en = 1'b0;
    err_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
